// File: rtl/video_pkg.sv
// Shared types and helpers for the parametrised raster timing engine.
package video_pkg;

    typedef enum logic [1:0] {REG_SYNC, REG_BACK, REG_ACT, REG_FRONT} region_t;

    typedef enum logic {ST_IDLE, ST_RUN} run_state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
        logic run;
    } timing_t;

    // MSB-aligned widening: output bits cycle through the channel from its MSB down.
    function automatic logic [31:0] expand_ch(input logic [31:0] c,
                                              input int unsigned ch_w,
                                              input int unsigned out_w);
        logic [31:0] res;
        int unsigned src;
        res = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < out_w) begin
                src = ch_w - 1 - (i % ch_w);
                res = {res[30:0], c[src[4:0]]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: counts SYNC, BACK, ACT, FRONT regions in order and wraps at the total.
module video_axis_counter
    import video_pkg::*;
#(
    parameter int unsigned SYNC  = 96,
    parameter int unsigned BACK  = 48,
    parameter int unsigned ACT   = 640,
    parameter int unsigned FRONT = 16,
    parameter int unsigned CW    = $clog2(SYNC + BACK + ACT + FRONT)
) (
    input  logic          CLOCK_25,
    input  logic          RESET_N,
    input  logic          step,
    input  logic          clear,
    output logic [CW-1:0] count,
    output region_t       region,
    output logic          last
);

    localparam int unsigned TOTAL = SYNC + BACK + ACT + FRONT;

    assign last = (count == CW'(TOTAL - 1));

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        region = REG_FRONT;
        if (32'(count) < SYNC) begin
            region = REG_SYNC;
        end else if (32'(count) < SYNC + BACK) begin
            region = REG_BACK;
        end else if (32'(count) < SYNC + BACK + ACT) begin
            region = REG_ACT;
        end
    end

endmodule

// File: rtl/video_timing_engine.sv
// Raster timing engine: frame-boundary run control, replicated framebuffer addressing,
// sync/blank alignment to RAM read latency and colour widening to the DAC.
module video_timing_engine
    import video_pkg::*;
#(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned CH_W        = 4,
    parameter int unsigned OUT_W       = 10,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              CLOCK_25,
    input  logic              RESET_N,
    input  logic              EN,
    output logic [ADDR_W-1:0] PIX_ADDR,
    input  logic [3*CH_W-1:0] PIX_DATA,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              BLANK,
    output logic [OUT_W-1:0]  R,
    output logic [OUT_W-1:0]  G,
    output logic [OUT_W-1:0]  B,
    output logic              FRAME_START,
    output logic              RUNNING
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
    localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
    localparam int unsigned Y_MASK  = (32'd1 << SCALE_SHIFT) - 32'd1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACT >> SCALE_SHIFT);
    localparam timing_t TIM_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0, fs: 1'b0, run: 1'b0};

    run_state_t          state, state_nxt;
    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    region_t             h_reg, v_reg;
    logic                h_last, v_last;
    logic                run, frame_last, active, line_end, row_adv;
    logic [HW-1:0]       x;
    logic [VW-1:0]       y;
    logic [ADDR_W-1:0]   row_base;
    timing_t             tim_raw;
    timing_t [READ_LAT:0] tim_pipe;
    timing_t             tim_out;

    assign run        = (state == ST_RUN);
    assign frame_last = h_last && v_last;

    video_axis_counter #(
        .SYNC (H_SYNC),
        .BACK (H_BACK),
        .ACT  (H_ACT),
        .FRONT(H_FRONT),
        .CW   (HW)
    ) u_h_cnt (
        .CLOCK_25(CLOCK_25),
        .RESET_N (RESET_N),
        .step    (run),
        .clear   (!run),
        .count   (h_cnt),
        .region  (h_reg),
        .last    (h_last)
    );

    video_axis_counter #(
        .SYNC (V_SYNC),
        .BACK (V_BACK),
        .ACT  (V_ACT),
        .FRONT(V_FRONT),
        .CW   (VW)
    ) u_v_cnt (
        .CLOCK_25(CLOCK_25),
        .RESET_N (RESET_N),
        .step    (run && h_last),
        .clear   (!run),
        .count   (v_cnt),
        .region  (v_reg),
        .last    (v_last)
    );

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stopping is only honoured on the last clock of a frame, so a frame always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (EN) state_nxt = ST_RUN;
            ST_RUN:  if (frame_last && !EN) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign active   = run && (h_reg == REG_ACT) && (v_reg == REG_ACT);
    assign x        = h_cnt - HW'(H_ACT0);
    assign y        = v_cnt - VW'(V_ACT0);
    assign line_end = (h_cnt == HW'(H_ACT0 + H_ACT - 1));
    assign row_adv  = active && line_end && ((32'(y) & Y_MASK) == Y_MASK);

    // row_base advances once per replicated line group, replacing y*width.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            row_base <= '0;
        end else if (!run || frame_last) begin
            row_base <= '0;
        end else if (row_adv) begin
            row_base <= row_base + ROW_STEP;
        end
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            PIX_ADDR <= '0;
        end else if (!run) begin
            PIX_ADDR <= '0;
        end else if (active) begin
            PIX_ADDR <= row_base + ADDR_W'(x >> SCALE_SHIFT);
        end
    end

    always_comb begin
        tim_raw = TIM_IDLE;
        if (run) begin
            tim_raw.hs  = (h_reg == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
            tim_raw.vs  = (v_reg == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
            tim_raw.act = active;
            tim_raw.fs  = (h_cnt == '0) && (v_cnt == '0);
            tim_raw.run = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            tim_pipe <= {(READ_LAT + 1){TIM_IDLE}};
        end else begin
            tim_pipe <= {tim_pipe[READ_LAT-1:0], tim_raw};
        end
    end

    assign tim_out = tim_pipe[READ_LAT];

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
            BLANK       <= 1'b0;
            FRAME_START <= 1'b0;
            RUNNING     <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
        end else begin
            HSYNC       <= tim_out.hs;
            VSYNC       <= tim_out.vs;
            BLANK       <= tim_out.act;
            FRAME_START <= tim_out.fs;
            RUNNING     <= tim_out.run;
            if (tim_out.act) begin
                R <= OUT_W'(expand_ch(32'(PIX_DATA[CH_W-1:0]), CH_W, OUT_W));
                G <= OUT_W'(expand_ch(32'(PIX_DATA[2*CH_W-1:CH_W]), CH_W, OUT_W));
                B <= OUT_W'(expand_ch(32'(PIX_DATA[3*CH_W-1:2*CH_W]), CH_W, OUT_W));
            end else begin
                R <= '0;
                G <= '0;
                B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_engine.sv
// Randomised bench for video_timing_engine: frame-position reference model, RAM model, two sync polarities.
module tb_video_timing_engine;

    localparam int unsigned H_SYNC = 2, H_BACK = 2, H_ACT = 8, H_FRONT = 2;
    localparam int unsigned V_SYNC = 1, V_BACK = 1, V_ACT = 4, V_FRONT = 1;
    localparam int unsigned SCALE_SHIFT = 1, READ_LAT = 2, CH_W = 4, OUT_W = 10, ADDR_W = 6;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int unsigned FRAME   = H_TOTAL * V_TOTAL;
    localparam int unsigned HA0     = H_SYNC + H_BACK;
    localparam int unsigned VA0     = V_SYNC + V_BACK;

    typedef struct {
        bit          run;
        int unsigned pos;
    } desc_t;

    typedef struct {
        logic hs, vs, bl, fs, rn;
        logic [OUT_W-1:0] r, g, b;
    } exp_t;

    logic CLOCK_25 = 1'b0;
    logic RESET_N  = 1'b0;
    logic EN       = 1'b0;

    logic [ADDR_W-1:0] addr_p0, addr_p1;
    logic [3*CH_W-1:0] data_p0, data_p1, rd_p0, rd_p1;
    logic hs_p0, vs_p0, bl_p0, fs_p0, rn_p0;
    logic hs_p1, vs_p1, bl_p1, fs_p1, rn_p1;
    logic [OUT_W-1:0] r_p0, g_p0, b_p0, r_p1, g_p1, b_p1;

    logic [3*CH_W-1:0] mem [2**ADDR_W];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    bit                m_run;
    int unsigned       m_pos;
    desc_t             q[$];
    desc_t             exp_d;
    logic [ADDR_W-1:0] exp_addr;

    always #5 CLOCK_25 = ~CLOCK_25;

    video_timing_engine #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT),
        .SYNC_POL(1'b0), .SCALE_SHIFT(SCALE_SHIFT), .READ_LAT(READ_LAT),
        .CH_W(CH_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) u_dut_p0 (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .EN(EN),
        .PIX_ADDR(addr_p0), .PIX_DATA(data_p0),
        .HSYNC(hs_p0), .VSYNC(vs_p0), .BLANK(bl_p0),
        .R(r_p0), .G(g_p0), .B(b_p0),
        .FRAME_START(fs_p0), .RUNNING(rn_p0)
    );

    video_timing_engine #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT),
        .SYNC_POL(1'b1), .SCALE_SHIFT(SCALE_SHIFT), .READ_LAT(READ_LAT),
        .CH_W(CH_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)
    ) u_dut_p1 (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .EN(EN),
        .PIX_ADDR(addr_p1), .PIX_DATA(data_p1),
        .HSYNC(hs_p1), .VSYNC(vs_p1), .BLANK(bl_p1),
        .R(r_p1), .G(g_p1), .B(b_p1),
        .FRAME_START(fs_p1), .RUNNING(rn_p1)
    );

    // Framebuffer with a two-clock read latency.
    always @(posedge CLOCK_25) begin
        rd_p0   <= mem[addr_p0];
        data_p0 <= rd_p0;
        rd_p1   <= mem[addr_p1];
        data_p1 <= rd_p1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_act(input int unsigned pos);
        int unsigned h, v;
        h = pos % H_TOTAL;
        v = pos / H_TOTAL;
        return (h >= HA0) && (h < HA0 + H_ACT) && (v >= VA0) && (v < VA0 + V_ACT);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int unsigned pos);
        int unsigned x, y;
        x = (pos % H_TOTAL) - HA0;
        y = (pos / H_TOTAL) - VA0;
        return ADDR_W'(((y >> SCALE_SHIFT) * (H_ACT >> SCALE_SHIFT)) + (x >> SCALE_SHIFT));
    endfunction

    function automatic logic [OUT_W-1:0] widen(input logic [CH_W-1:0] c);
        logic [3*CH_W-1:0] rep;
        rep = {c, c, c};
        return rep[3*CH_W-1 -: OUT_W];
    endfunction

    function automatic exp_t expect_of(input desc_t d, input logic pol);
        exp_t e;
        logic [3*CH_W-1:0] w;
        int unsigned h, v;
        e = '{hs: ~pol, vs: ~pol, bl: 1'b0, fs: 1'b0, rn: 1'b0, r: '0, g: '0, b: '0};
        if (d.run) begin
            h    = d.pos % H_TOTAL;
            v    = d.pos / H_TOTAL;
            e.hs = (h < H_SYNC) ? pol : ~pol;
            e.vs = (v < V_SYNC) ? pol : ~pol;
            e.fs = (d.pos == 0);
            e.rn = 1'b1;
            if (is_act(d.pos)) begin
                w    = mem[addr_of(d.pos)];
                e.bl = 1'b1;
                e.r  = widen(w[CH_W-1:0]);
                e.g  = widen(w[2*CH_W-1:CH_W]);
                e.b  = widen(w[3*CH_W-1:2*CH_W]);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_pos    = 0;
        exp_d    = '{run: 1'b0, pos: 0};
        exp_addr = '0;
        q.delete();
        repeat (3) q.push_back('{run: 1'b0, pos: 0});
    endtask

    // Called just after each rising edge; EN is the value that edge sampled.
    task automatic model_step();
        desc_t cur;
        cur = '{run: m_run, pos: m_pos};
        if (!cur.run) exp_addr = '0;
        else if (is_act(cur.pos)) exp_addr = addr_of(cur.pos);
        q.push_back(cur);
        exp_d = q.pop_front();
        if (!m_run) begin
            if (EN) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos = 0;
            if (!EN) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_dut(input string s, input logic pol,
                             input logic hs, input logic vs, input logic bl,
                             input logic fs, input logic rn,
                             input logic [OUT_W-1:0] r, input logic [OUT_W-1:0] g,
                             input logic [OUT_W-1:0] b, input logic [ADDR_W-1:0] a);
        exp_t e;
        e = expect_of(exp_d, pol);
        check({s, ".hsync"},   32'(hs), 32'(e.hs));
        check({s, ".vsync"},   32'(vs), 32'(e.vs));
        check({s, ".blank"},   32'(bl), 32'(e.bl));
        check({s, ".fstart"},  32'(fs), 32'(e.fs));
        check({s, ".running"}, 32'(rn), 32'(e.rn));
        check({s, ".r"},       32'(r),  32'(e.r));
        check({s, ".g"},       32'(g),  32'(e.g));
        check({s, ".b"},       32'(b),  32'(e.b));
        check({s, ".addr"},    32'(a),  32'(exp_addr));
    endtask

    task automatic check_all();
        check_dut("pol0", 1'b0, hs_p0, vs_p0, bl_p0, fs_p0, rn_p0, r_p0, g_p0, b_p0, addr_p0);
        check_dut("pol1", 1'b1, hs_p1, vs_p1, bl_p1, fs_p1, rn_p1, r_p1, g_p1, b_p1, addr_p1);
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        model_step();
        @(negedge CLOCK_25);
        check_all();
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = (3*CH_W)'($urandom);
        mem[0] = 12'h80F;
        mem[5] = 12'h80F;
        mem[7] = 12'h000;
        model_reset();

        repeat (3) @(negedge CLOCK_25);
        check_all();
        RESET_N = 1'b1;
        EN      = 1'b1;

        repeat (3 * FRAME + 10) tick();

        // Stop request at line 2: the frame must finish, then the pipeline drains.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            found = m_run && (m_pos / H_TOTAL == 2);
        end
        check("wait_v2", 32'(found), 32'd1);
        EN = 1'b0;
        repeat (FRAME + 10) tick();

        // Single-clock EN pulse while idle starts exactly one frame.
        EN = 1'b1;
        tick();
        EN = 1'b0;
        repeat (FRAME + 10) tick();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) EN = ~EN;
            tick();
        end

        // Asynchronous reset while active pixels are on the pins.
        EN    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            tick();
            found = exp_d.run && is_act(exp_d.pos);
        end
        check("mid_active_window", 32'(found), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLOCK_25);
        @(negedge CLOCK_25);
        check_all();
        RESET_N = 1'b1;
        EN      = 1'b1;
        repeat (2 * FRAME + 10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
